// File: rtl/regfile_wb_queue.sv
// Write-back buffer feeding the register-file write ports: dual-lane in-order
// enqueue, dual-port registered drain with same-address serialisation.
// Optional macro WBQ_FWD_EN adds a combinational lookup/forwarding port.
module regfile_wb_queue #(
  parameter int QDEPTH     = 8,
  parameter int QINDEX     = 3,
  parameter int SRAM_INDEX = 5,
  parameter int SRAM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in0_valid_i,
  input  logic [SRAM_INDEX-1:0] in0_addr_i,
  input  logic [SRAM_WIDTH-1:0] in0_data_i,
  input  logic                  in1_valid_i,
  input  logic [SRAM_INDEX-1:0] in1_addr_i,
  input  logic [SRAM_WIDTH-1:0] in1_data_i,
  output logic                  in_ready_o,
  input  logic                  stall_i,
  output logic                  we0_o,
  output logic [SRAM_INDEX-1:0] addr0wr_o,
  output logic [SRAM_WIDTH-1:0] data0wr_o,
  output logic                  we1_o,
  output logic [SRAM_INDEX-1:0] addr1wr_o,
  output logic [SRAM_WIDTH-1:0] data1wr_o,
  output logic [QINDEX:0]       count_o,
  output logic                  empty_o,
  output logic                  full_o,
`ifdef WBQ_FWD_EN
  input  logic [SRAM_INDEX-1:0] lookup_addr_i,
  output logic                  fwd_hit_o,
  output logic [SRAM_WIDTH-1:0] fwd_data_o,
`endif
  output logic                  drop_err_o
);

  localparam int CW = QINDEX + 1;

  typedef struct packed {
    logic [SRAM_INDEX-1:0] addr;
    logic [SRAM_WIDTH-1:0] data;
  } entry_t;

  entry_t            mem [QDEPTH];
  logic [QINDEX-1:0] head;
  logic [QINDEX-1:0] tail;
  logic [QINDEX-1:0] head1;
  logic [QINDEX-1:0] tail1;
  logic [CW-1:0]     count;
  logic              acc0;
  logic              acc1;
  logic [1:0]        enq;
  logic [1:0]        pop;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    in_ready_o = (count <= CW'(QDEPTH - 2));
    acc0       = in_ready_o && in0_valid_i;
    acc1       = in_ready_o && in1_valid_i;
    enq        = {1'b0, acc0} + {1'b0, acc1};
    head1      = head + QINDEX'(1);
    tail1      = acc0 ? tail + QINDEX'(1) : tail;
    pop        = 2'd0;
    if (!stall_i && count != '0) begin
      // Two writes to one register in the same cycle would race in the
      // register file, so the younger one waits a cycle.
      if (count == CW'(1) || mem[head].addr == mem[head1].addr)
        pop = 2'd1;
      else
        pop = 2'd2;
    end
  end

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(QDEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      we0_o      <= 1'b0;
      addr0wr_o  <= '0;
      data0wr_o  <= '0;
      we1_o      <= 1'b0;
      addr1wr_o  <= '0;
      data1wr_o  <= '0;
      drop_err_o <= 1'b0;
    end else begin
      head  <= head + QINDEX'(pop);
      tail  <= tail + QINDEX'(enq);
      count <= count + CW'(enq) - CW'(pop);
      if (!in_ready_o && (in0_valid_i || in1_valid_i))
        drop_err_o <= 1'b1;
      we0_o <= (pop != 2'd0);
      if (pop != 2'd0) begin
        addr0wr_o <= mem[head].addr;
        data0wr_o <= mem[head].data;
      end
      we1_o <= (pop == 2'd2);
      if (pop == 2'd2) begin
        addr1wr_o <= mem[head1].addr;
        data1wr_o <= mem[head1].data;
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count/head/tail alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (acc0) mem[tail]  <= '{addr: in0_addr_i, data: in0_data_i};
    if (acc1) mem[tail1] <= '{addr: in1_addr_i, data: in1_data_i};
  end

`ifdef WBQ_FWD_EN
  // Later matches overwrite earlier ones: port 0, port 1, then queue oldest
  // to youngest, so the youngest writer of the address wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (we0_o && addr0wr_o == lookup_addr_i) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = data0wr_o;
    end
    if (we1_o && addr1wr_o == lookup_addr_i) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = data1wr_o;
    end
    for (int i = 0; i < QDEPTH; i++) begin
      if (CW'(i) < count && mem[head + QINDEX'(i)].addr == lookup_addr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = mem[head + QINDEX'(i)].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue; covers the forwarding
// port as well when WBQ_FWD_EN is defined.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in0_valid_i = 1'b0;
  logic [4:0]  in0_addr_i = '0;
  logic [31:0] in0_data_i = '0;
  logic        in1_valid_i = 1'b0;
  logic [4:0]  in1_addr_i = '0;
  logic [31:0] in1_data_i = '0;
  logic        in_ready_o;
  logic        stall_i = 1'b0;
  logic        we0_o;
  logic [4:0]  addr0wr_o;
  logic [31:0] data0wr_o;
  logic        we1_o;
  logic [4:0]  addr1wr_o;
  logic [31:0] data1wr_o;
  logic [3:0]  count_o;
  logic        empty_o;
  logic        full_o;
  logic        drop_err_o;
`ifdef WBQ_FWD_EN
  logic [4:0]  lookup_addr_i = '0;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  regfile_wb_queue dut (
    .clk         (clk),
    .reset       (reset),
    .in0_valid_i (in0_valid_i),
    .in0_addr_i  (in0_addr_i),
    .in0_data_i  (in0_data_i),
    .in1_valid_i (in1_valid_i),
    .in1_addr_i  (in1_addr_i),
    .in1_data_i  (in1_data_i),
    .in_ready_o  (in_ready_o),
    .stall_i     (stall_i),
    .we0_o       (we0_o),
    .addr0wr_o   (addr0wr_o),
    .data0wr_o   (data0wr_o),
    .we1_o       (we1_o),
    .addr1wr_o   (addr1wr_o),
    .data1wr_o   (data1wr_o),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
`ifdef WBQ_FWD_EN
    .lookup_addr_i (lookup_addr_i),
    .fwd_hit_o     (fwd_hit_o),
    .fwd_data_o    (fwd_data_o),
`endif
    .drop_err_o  (drop_err_o)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    in0_valid_i = v0; in0_addr_i = a0; in0_data_i = d0;
    in1_valid_i = v1; in1_addr_i = a1; in1_data_i = d1;
  endtask

  task automatic clear_in();
    in0_valid_i = 1'b0;
    in1_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (we0_o !== 1'b0 || we1_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_we: got we0=%b we1=%b expected 0 0", we0_o, we1_o);
    end
    tests_run++;
    if (count_o !== 4'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_count: got count=%0d empty=%b full=%b expected 0 1 0", count_o, empty_o, full_o);
    end
    tests_run++;
    if (drop_err_o !== 1'b0 || in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_flags: got drop=%b ready=%b expected 0 1", drop_err_o, in_ready_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_in(1'b1, 5'd3, 32'hA5A5_0001, 1'b1, 5'd7, 32'h0000_0002);
    tick();
    clear_in();
    tests_run++;
    if (count_o !== 4'd2 || we0_o !== 1'b0) begin
      tests_failed++; $display("FAIL basic_enq: got count=%0d we0=%b expected 2 0", count_o, we0_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || addr0wr_o !== 5'd3 || data0wr_o !== 32'hA5A5_0001) begin
      tests_failed++;
      $display("FAIL basic_port0: got we=%b addr=%0d data=%h expected 1 3 a5a50001", we0_o, addr0wr_o, data0wr_o);
    end
    tests_run++;
    if (we1_o !== 1'b1 || addr1wr_o !== 5'd7 || data1wr_o !== 32'h0000_0002) begin
      tests_failed++;
      $display("FAIL basic_port1: got we=%b addr=%0d data=%h expected 1 7 00000002", we1_o, addr1wr_o, data1wr_o);
    end
    tests_run++;
    if (count_o !== 4'd0 || empty_o !== 1'b1) begin
      tests_failed++; $display("FAIL basic_count: got count=%0d empty=%b expected 0 1", count_o, empty_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b0 || we1_o !== 1'b0) begin
      tests_failed++; $display("FAIL basic_idle: got we0=%b we1=%b expected 0 0", we0_o, we1_o);
    end
  endtask

  task automatic test_same_addr();
    set_in(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22);
    tick();
    clear_in();
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || addr0wr_o !== 5'd9 || data0wr_o !== 32'h11 || we1_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_first: got we0=%b addr=%0d data=%h we1=%b expected 1 9 11 0", we0_o, addr0wr_o, data0wr_o, we1_o);
    end
    tests_run++;
    if (count_o !== 4'd1) begin
      tests_failed++; $display("FAIL same_count: got %0d expected 1", count_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || addr0wr_o !== 5'd9 || data0wr_o !== 32'h22 || we1_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_second: got we0=%b addr=%0d data=%h we1=%b expected 1 9 22 0", we0_o, addr0wr_o, data0wr_o, we1_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b0 || count_o !== 4'd0) begin
      tests_failed++; $display("FAIL same_idle: got we0=%b count=%0d expected 0 0", we0_o, count_o);
    end
  endtask

  task automatic test_single_lane();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    tick();
    clear_in();
    tests_run++;
    if (count_o !== 4'd1) begin
      tests_failed++; $display("FAIL lane1_count: got %0d expected 1", count_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || addr0wr_o !== 5'd6 || data0wr_o !== 32'h66 || we1_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL lane1_drain: got we0=%b addr=%0d data=%h we1=%b expected 1 6 66 0", we0_o, addr0wr_o, data0wr_o, we1_o);
    end
    tick();
  endtask

  task automatic test_stall_wrap();
    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 5'(10 + 2 * k), 32'h100 + 32'(2 * k), 1'b1, 5'(11 + 2 * k), 32'h101 + 32'(2 * k));
      tick();
      tests_run++;
      if (we0_o !== 1'b0 || we1_o !== 1'b0 || count_o !== 4'(2 * (k + 1))) begin
        tests_failed++;
        $display("FAIL stall_fill%0d: got we0=%b we1=%b count=%0d expected 0 0 %0d", k, we0_o, we1_o, count_o, 2 * (k + 1));
      end
      if (k == 2) begin
        tests_run++;
        if (in_ready_o !== 1'b1 || full_o !== 1'b0) begin
          tests_failed++; $display("FAIL stall_six: got ready=%b full=%b expected 1 0", in_ready_o, full_o);
        end
      end
    end
    tests_run++;
    if (in_ready_o !== 1'b0 || full_o !== 1'b1 || drop_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_full: got ready=%b full=%b drop=%b expected 0 1 0", in_ready_o, full_o, drop_err_o);
    end
    set_in(1'b1, 5'd30, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    tick();
    clear_in();
    tests_run++;
    if (drop_err_o !== 1'b1 || count_o !== 4'd8) begin
      tests_failed++; $display("FAIL stall_drop: got drop=%b count=%0d expected 1 8", drop_err_o, count_o);
    end
    stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (we0_o !== 1'b1 || addr0wr_o !== 5'(10 + 2 * k) || data0wr_o !== 32'h100 + 32'(2 * k)) begin
        tests_failed++;
        $display("FAIL wrap_port0_%0d: got we=%b addr=%0d data=%h expected 1 %0d %h", k, we0_o, addr0wr_o, data0wr_o, 10 + 2 * k, 32'h100 + 32'(2 * k));
      end
      tests_run++;
      if (we1_o !== 1'b1 || addr1wr_o !== 5'(11 + 2 * k) || data1wr_o !== 32'h101 + 32'(2 * k)) begin
        tests_failed++;
        $display("FAIL wrap_port1_%0d: got we=%b addr=%0d data=%h expected 1 %0d %h", k, we1_o, addr1wr_o, data1wr_o, 11 + 2 * k, 32'h101 + 32'(2 * k));
      end
      tests_run++;
      if (count_o !== 4'(6 - 2 * k)) begin
        tests_failed++; $display("FAIL wrap_count%0d: got %0d expected %0d", k, count_o, 6 - 2 * k);
      end
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b0 || we1_o !== 1'b0 || drop_err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_done: got we0=%b we1=%b drop=%b expected 0 0 1", we0_o, we1_o, drop_err_o);
    end
  endtask

  task automatic test_reset_mid();
    stall_i = 1'b1;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    tick();
    set_in(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'h0);
    tick();
    clear_in();
    tests_run++;
    if (count_o !== 4'd5) begin
      tests_failed++; $display("FAIL rmid_count5: got %0d expected 5", count_o);
    end
    stall_i = 1'b0;
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || we1_o !== 1'b1 || count_o !== 4'd3) begin
      tests_failed++;
      $display("FAIL rmid_pre: got we0=%b we1=%b count=%0d expected 1 1 3", we0_o, we1_o, count_o);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (we0_o !== 1'b0 || we1_o !== 1'b0 || addr0wr_o !== 5'd0 || data1wr_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL rmid_async: got we0=%b we1=%b addr0=%0d data1=%h expected 0 0 0 0", we0_o, we1_o, addr0wr_o, data1wr_o);
    end
    tests_run++;
    if (count_o !== 4'd0 || drop_err_o !== 1'b0 || empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_state: got count=%0d drop=%b empty=%b expected 0 0 1", count_o, drop_err_o, empty_o);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (we0_o !== 1'b0 || we1_o !== 1'b0 || count_o !== 4'd0) begin
        tests_failed++;
        $display("FAIL rmid_after%0d: got we0=%b we1=%b count=%0d expected 0 0 0", k, we0_o, we1_o, count_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++) begin
      set_in(1'b1, 5'(2 * j), 32'h1000 + 32'(j), 1'b1, 5'(2 * j + 1), 32'h2000 + 32'(j));
      tick();
      tests_run++;
      if (count_o !== 4'd2 || in_ready_o !== 1'b1) begin
        tests_failed++; $display("FAIL b2b_steady%0d: got count=%0d ready=%b expected 2 1", j, count_o, in_ready_o);
      end
      if (j >= 1) begin
        tests_run++;
        if (we0_o !== 1'b1 || addr0wr_o !== 5'(2 * (j - 1)) || data0wr_o !== 32'h1000 + 32'(j - 1)) begin
          tests_failed++;
          $display("FAIL b2b_port0_%0d: got we=%b addr=%0d data=%h expected 1 %0d %h", j, we0_o, addr0wr_o, data0wr_o, 2 * (j - 1), 32'h1000 + 32'(j - 1));
        end
        tests_run++;
        if (we1_o !== 1'b1 || addr1wr_o !== 5'(2 * j - 1) || data1wr_o !== 32'h2000 + 32'(j - 1)) begin
          tests_failed++;
          $display("FAIL b2b_port1_%0d: got we=%b addr=%0d data=%h expected 1 %0d %h", j, we1_o, addr1wr_o, data1wr_o, 2 * j - 1, 32'h2000 + 32'(j - 1));
        end
      end
    end
    clear_in();
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || addr0wr_o !== 5'd14 || we1_o !== 1'b1 || addr1wr_o !== 5'd15 || count_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b_tail: got we0=%b a0=%0d we1=%b a1=%0d count=%0d expected 1 14 1 15 0", we0_o, addr0wr_o, we1_o, addr1wr_o, count_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b0 || drop_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_end: got we0=%b drop=%b expected 0 0", we0_o, drop_err_o);
    end
  endtask

`ifdef WBQ_FWD_EN
  task automatic test_fwd();
    stall_i = 1'b1;
    set_in(1'b1, 5'd4, 32'h10, 1'b1, 5'd4, 32'h20);
    tick();
    clear_in();
    lookup_addr_i = 5'd4;
    #1;
    tests_run++;
    if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h20) begin
      tests_failed++; $display("FAIL fwd_queue: got hit=%b data=%h expected 1 20", fwd_hit_o, fwd_data_o);
    end
    lookup_addr_i = 5'd5;
    #1;
    tests_run++;
    if (fwd_hit_o !== 1'b0 || fwd_data_o !== 32'h0) begin
      tests_failed++; $display("FAIL fwd_miss: got hit=%b data=%h expected 0 0", fwd_hit_o, fwd_data_o);
    end
    lookup_addr_i = 5'd4;
    stall_i = 1'b0;
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || data0wr_o !== 32'h10 || fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h20) begin
      tests_failed++;
      $display("FAIL fwd_over_port: got we0=%b d0=%h hit=%b data=%h expected 1 10 1 20", we0_o, data0wr_o, fwd_hit_o, fwd_data_o);
    end
    tick();
    tests_run++;
    if (we0_o !== 1'b1 || count_o !== 4'd0 || fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h20) begin
      tests_failed++;
      $display("FAIL fwd_port0: got we0=%b count=%0d hit=%b data=%h expected 1 0 1 20", we0_o, count_o, fwd_hit_o, fwd_data_o);
    end
    tick();
    tests_run++;
    if (fwd_hit_o !== 1'b0 || fwd_data_o !== 32'h0) begin
      tests_failed++; $display("FAIL fwd_gone: got hit=%b data=%h expected 0 0", fwd_hit_o, fwd_data_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_same_addr();
    test_single_lane();
    test_stall_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef WBQ_FWD_EN
    test_fwd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
